apb_to_ahb_bridge: RTL and testbench

Single-clock bridge that is an APB completer on its upstream side and an AHB-Lite manager on its downstream side: it converts each APB transfer into exactly one AHB single (NONSEQ, word-sized) transfer. It is the reverse-direction counterpart of `ahb_to_apb_bridge`. It lets APB-attached controllers reach AHB memory (for example the AHB-side memories behind the existing fabric) without a second bus manager. Wait states and error responses on the AHB side map onto PREADY and PSLVERR.

---
 rtl/apb_to_ahb_bridge_if.sv | 34 +++
 rtl/apb_to_ahb_bridge.sv | 90 +++++++++
 tb/tb_apb_to_ahb_bridge.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_to_ahb_bridge_if.sv
// APB completer / AHB-Lite manager signal bundle for apb_to_ahb_bridge.
// The bridge uses the slave modport; the surrounding system uses master.
interface apb_to_ahb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, HRDATA, HREADY, HRESP,
    output PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, HRDATA, HREADY, HRESP,
    input  PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
endinterface

// File: rtl/apb_to_ahb_bridge.sv
// APB completer to AHB-Lite manager bridge: each APB transfer becomes one
// non-pipelined AHB NONSEQ single; AHB waits/errors map to PREADY/PSLVERR.
module apb_to_ahb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  apb_to_ahb_bridge_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t                state_q;
  logic [1:0]            htrans_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Only a setup phase starts a transfer; the holding registers drive the AHB side directly.
          if (bus.PSEL && !bus.PENABLE) begin
            haddr_q  <= bus.PADDR;
            hwrite_q <= bus.PWRITE;
            hwdata_q <= bus.PWDATA;
            htrans_q <= HTRANS_NONSEQ;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.HREADY) begin
            htrans_q <= HTRANS_IDLE;
            state_q  <= S_DATA;
          end
        end
        S_DATA: begin
          // HRESP is only trusted on the HREADY=1 edge, so two-cycle errors collapse to one flag.
          if (bus.HREADY) begin
            if (!hwrite_q) begin
              prdata_q <= bus.HRDATA;
            end
            pslverr_q <= bus.HRESP;
            pready_q  <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.HTRANS  = htrans_q;
  assign bus.HADDR   = haddr_q;
  assign bus.HWRITE  = hwrite_q;
  assign bus.HWDATA  = hwdata_q;
  assign bus.HSIZE   = 3'($clog2(DATA_WIDTH / 8));
  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Randomised bench for apb_to_ahb_bridge: an APB driver, a scripted AHB
// slave memory and a transaction-level reference model of expected results.
module tb_apb_to_ahb_bridge;

  localparam logic [31:0] ERR_DATA = 32'hE0E0_E0E0;

  logic HCLK = 1'b0;
  logic HRESETn;

  apb_to_ahb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_to_ahb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave behaviour knobs for the next AHB transfer, plus what the slave observed.
  int          cfg_aw  = 0;
  int          cfg_dw  = 0;
  bit          cfg_err = 1'b0;
  int          ahb_cnt = 0;
  int          rst_cnt = 0;
  logic [31:0] s_addr;
  logic        s_write;
  logic [31:0] s_wdata;
  int          s_rc;
  logic [31:0] smem [logic [31:0]];

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : ~a;
  endfunction

  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (HRESETn && bus.HTRANS == 2'b10) begin
        s_addr  = bus.HADDR;
        s_write = bus.HWRITE;
        s_rc    = rst_cnt;
        ahb_cnt++;
        for (int i = 0; i < cfg_aw; i++) begin
          bus.HREADY = 1'b0;
          @(negedge HCLK);
          chk("addr_stall_htrans", 64'(bus.HTRANS), 64'(2'b10));
          chk("addr_stall_haddr", 64'(bus.HADDR), 64'(s_addr));
          chk("addr_stall_hwrite", 64'(bus.HWRITE), 64'(s_write));
        end
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        chk("data_phase_htrans_idle", 64'(bus.HTRANS), 64'(2'b00));
        s_wdata = bus.HWDATA;
        for (int i = 0; i < cfg_dw; i++) begin
          bus.HREADY = 1'b0;
          @(negedge HCLK);
        end
        if (cfg_err) begin
          bus.HREADY = 1'b0;
          bus.HRESP  = 1'b1;
          @(negedge HCLK);
          bus.HREADY = 1'b1;
          bus.HRDATA = ERR_DATA;
          @(negedge HCLK);
          bus.HRESP  = 1'b0;
        end else begin
          bus.HREADY = 1'b1;
          bus.HRESP  = 1'b0;
          if (!s_write) bus.HRDATA = slave_read(s_addr);
          @(posedge HCLK);
          if (s_write && rst_cnt == s_rc) smem[s_addr] = s_wdata;
        end
      end
    end
  end

  // Reference model: plain memory semantics plus latency arithmetic.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input int aw, input int dw, input bit err);
    int          cyc;
    int          cnt0;
    logic [31:0] exp_rd;
    cfg_aw  = aw;
    cfg_dw  = dw;
    cfg_err = err;
    cnt0    = ahb_cnt;
    if (!wr) exp_rd = err ? ERR_DATA : ref_read(addr);
    else     exp_rd = last_rd;
    if (wr && !err) ref_mem[addr] = wdata;
    last_rd = exp_rd;

    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wdata;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    cyc = 0;
    while (!bus.PREADY && cyc < 200) begin
      @(posedge HCLK); #1;
      cyc++;
    end
    chk("pready_latency", 64'(cyc), 64'(2 + aw + dw + (err ? 1 : 0)));
    chk("pslverr", 64'(bus.PSLVERR), 64'(err));
    chk("prdata", 64'(bus.PRDATA), 64'(exp_rd));
    @(posedge HCLK); #1;
    chk("pready_single_cycle", 64'(bus.PREADY), 64'(0));
    chk("ahb_xfer_count", 64'(ahb_cnt - cnt0), 64'(1));
    chk("haddr_issued", 64'(s_addr), 64'(addr));
    chk("hwrite_issued", 64'(s_write), 64'(wr));
    if (wr) chk("hwdata_issued", 64'(s_wdata), 64'(wdata));
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  initial begin
    HRESETn     = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PADDR   = '0;
    bus.PWRITE  = 1'b0;
    bus.PWDATA  = '0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_htrans", 64'(bus.HTRANS), 64'(0));
    chk("rst_haddr", 64'(bus.HADDR), 64'(0));
    chk("rst_hwrite", 64'(bus.HWRITE), 64'(0));
    chk("rst_hwdata", 64'(bus.HWDATA), 64'(0));
    chk("rst_prdata", 64'(bus.PRDATA), 64'(0));
    chk("rst_pready", 64'(bus.PREADY), 64'(0));
    chk("rst_pslverr", 64'(bus.PSLVERR), 64'(0));
    chk("hsize", 64'(bus.HSIZE), 64'(3'b010));
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    apb_xfer(32'h04, 1'b1, 32'hBEEF_BEEF, 0, 0, 1'b0);
    apb_xfer(32'h04, 1'b0, 32'h0, 0, 0, 1'b0);
    apb_xfer(32'h10, 1'b1, 32'h1234_5678, 2, 3, 1'b0);
    apb_xfer(32'h10, 1'b0, 32'h0, 0, 0, 1'b0);
    apb_xfer(32'hFC, 1'b0, 32'h0, 0, 0, 1'b1);
    apb_xfer(32'h04, 1'b0, 32'h0, 0, 0, 1'b0);
    apb_xfer(32'h08, 1'b1, 32'hCAFE_0001, 0, 0, 1'b0);
    apb_xfer(32'h08, 1'b0, 32'h0, 0, 0, 1'b0);

    // Reset asserted while the slave stalls the data phase.
    cfg_aw      = 0;
    cfg_dw      = 4;
    cfg_err     = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = 32'h20;
    bus.PWRITE  = 1'b1;
    bus.PWDATA  = 32'h5555_AAAA;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    rst_cnt++;
    HRESETn = 1'b0;
    #1;
    chk("midrst_htrans", 64'(bus.HTRANS), 64'(0));
    chk("midrst_pready", 64'(bus.PREADY), 64'(0));
    chk("midrst_haddr", 64'(bus.HADDR), 64'(0));
    chk("midrst_hwdata", 64'(bus.HWDATA), 64'(0));
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    last_rd = '0;
    repeat (8) @(posedge HCLK);
    #1;
    chk("post_rst_idle", 64'(bus.HTRANS), 64'(0));
    apb_xfer(32'h0C, 1'b1, 32'hFACE_FEED, 0, 0, 1'b0);
    apb_xfer(32'h0C, 1'b0, 32'h0, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      apb_xfer({26'd0, 4'($urandom_range(0, 15)), 2'b00}, 1'($urandom_range(0, 1)), $urandom,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge HCLK); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
